// File: rtl/tessia_pkg.sv
// Shared constants and the fetch queue entry type for the Tessia front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tessia_pkg;

  // Native datapath width of the core.
  localparam int XLEN     = 32;

  // Sequential fetch advances by one 32-bit instruction.
  localparam int PC_STEP  = 4;

  // Reading the PC from decode returns the instruction address plus two
  // words (ARM read-PC semantics).
  localparam int PC_AHEAD = 8;

  // One queued fetch: the instruction word and the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage : tessia_pkg

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry FIFO with synchronous flush, used as the prefetch queue.
// Latency: a pushed entry is visible on dout the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module fetch_fifo
  import tessia_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  // Storage needs no reset: nothing reads it while count is zero.
  T mem_q [DEPTH];
  T mem_d [DEPTH];

  // Pointers wrap naturally at DEPTH (power of 2); count tells full from empty.
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q,  count_d;

  logic do_push;
  logic do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];

  // A full queue still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Next-state for storage, pointers and occupancy; flush discards everything.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : fetch_fifo

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, prefetches from combinational imem into a queue, presents the head to decode.
// Latency: reset release to first ValidD 1 cycle; redirect to target at decode 2 cycles.
// Backpressure: StallD holds the head; when the queue is full PCF holds and InstructionF is ignored.
module fetch_queue
  import tessia_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [WIDTH-1:0]         PCF,
  input  logic [WIDTH-1:0]         InstructionF,
  input  logic                     PCSrcW,
  input  logic [WIDTH-1:0]         ResultW,
  input  logic                     StallD,
  output logic                     ValidD,
  output logic [WIDTH-1:0]         InstructionD,
  output logic [WIDTH-1:0]         PCD,
  output logic [WIDTH-1:0]         PCPlus8D,
  output logic [$clog2(DEPTH):0]   CountQ
);

  // Entry layout matches tessia_pkg::fetch_entry_t but follows WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
  } entry_t;

  logic [WIDTH-1:0]       pc_q, pc_d;
  logic                   push;
  logic                   pop;
  entry_t                 wr_entry;
  entry_t                 head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  // Decode consumes the head whenever one is present and it is not stalled.
  // A pop in a redirect cycle still counts: the instruction was handed over.
  assign pop  = !fifo_empty && !StallD;

  // Fetch whenever there is room (or room is being made) and no redirect is
  // pending; a redirect cycle's fetch address is stale, so nothing is kept.
  assign push = !PCSrcW && (!fifo_full || pop);

  assign wr_entry.instr = InstructionF;
  assign wr_entry.pc    = pc_q;

  // Next fetch address: redirect beats sequential advance; a blocked fetch holds.
  always_comb begin
    pc_d = pc_q;
    if (PCSrcW) begin
      pc_d = ResultW;
    end else if (push) begin
      pc_d = pc_q + WIDTH'(PC_STEP);
    end
  end

  // PC register; reset beats a simultaneous redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (PCSrcW),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign PCF    = pc_q;
  assign CountQ = fifo_count;
  assign ValidD = !fifo_empty;

  // Decode-side fields come only from queue storage and are zeroed when empty
  // so stale entries never leak into decode.
  always_comb begin
    InstructionD = '0;
    PCD          = '0;
    PCPlus8D     = '0;
    if (!fifo_empty) begin
      InstructionD = head.instr;
      PCD          = head.pc;
      PCPlus8D     = head.pc + WIDTH'(PC_AHEAD);
    end
  end

endmodule : fetch_queue
